// File: rtl/irda_tx_pkg.sv
// Shared types and frame helpers for the IrDA TX framer.
package irda_tx_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic IDLE_LVL    = 1'b1;
    localparam int   MAX_DATA_W  = 16;
    localparam int   MAX_FRAME_W = 1 + MAX_DATA_W + 1 + 2;

    function automatic int frame_w(input int data_w, input int parity_en, input int stop_bits);
        return 1 + data_w + parity_en + stop_bits;
    endfunction

    // Returns the frame right-aligned in a max-width vector; bits above the frame are 0.
    function automatic logic [MAX_FRAME_W-1:0] build_frame(
        input logic [MAX_DATA_W-1:0] dat,
        input int data_w,
        input int parity_en,
        input int parity_odd,
        input int stop_bits
    );
        logic [MAX_FRAME_W-1:0] f;
        logic [MAX_DATA_W-1:0]  mask;
        logic [MAX_DATA_W-1:0]  d;
        logic                   pbit;
        mask = (MAX_DATA_W'(1) << data_w) - MAX_DATA_W'(1);
        d    = dat & mask;
        f    = {MAX_FRAME_W{IDLE_LVL}};
        f    = f & ~(MAX_FRAME_W'(mask) << 1);
        f    = f | (MAX_FRAME_W'(d) << 1);
        f    = f & ~MAX_FRAME_W'(1);
        pbit = (parity_odd != 0) ? ~(^d) : (^d);
        if ((parity_en != 0) && !pbit) begin
            f = f & ~(MAX_FRAME_W'(1) << (data_w + 1));
        end
        f = f & ((MAX_FRAME_W'(1) << frame_w(data_w, parity_en, stop_bits)) - MAX_FRAME_W'(1));
        return f;
    endfunction

endpackage

// File: rtl/irda_tx_hold.sv
// One-entry holding register that queues the next word while a frame shifts out.
module irda_tx_hold #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] dat,
    input  logic              bypass,
    input  logic              drain,
    output logic [DATA_W-1:0] hold,
    output logic              hold_valid,
    output logic              ready,
    output logic              overrun
);

    assign ready = !hold_valid;

    // A bypassed word goes straight to the shifter, so it must not also be queued here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= load && hold_valid;
            if (drain) begin
                hold_valid <= 1'b0;
            end else if (load && !hold_valid && !bypass) begin
                hold       <= dat;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/irda_tx_framer.sv
// UART/IrDA TX framer: builds start/data/parity/stop frames and shifts them out LSB-first on bit_tick.
module irda_tx_framer
    import irda_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_tick,
    input  logic              load,
    input  logic [DATA_W-1:0] dat,
    output logic              ready,
    output logic              busy,
    output logic              txd,
    output logic              done,
    output logic              overrun
);

    localparam int FRAME_W = frame_w(DATA_W, PARITY_EN, STOP_BITS);
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    state_t              state, state_nxt;
    logic [FRAME_W-1:0]  shreg, shreg_nxt, frame_new;
    logic [CNT_W-1:0]    bit_cnt, cnt_nxt;
    logic                done_nxt;
    logic                bypass, drain, accept;
    logic                hold_valid;
    logic [DATA_W-1:0]   hold;

    irda_tx_hold #(.DATA_W(DATA_W)) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .dat        (dat),
        .bypass     (bypass),
        .drain      (drain),
        .hold       (hold),
        .hold_valid (hold_valid),
        .ready      (ready),
        .overrun    (overrun)
    );

    // Draining and bypassing are mutually exclusive (bypass needs ready), so one frame builder serves both.
    assign frame_new = FRAME_W'(build_frame(MAX_DATA_W'(hold_valid ? hold : dat),
                                            DATA_W, PARITY_EN, PARITY_ODD, STOP_BITS));
    assign accept    = load && ready;

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = bit_cnt;
        done_nxt  = 1'b0;
        bypass    = 1'b0;
        drain     = 1'b0;
        if (bit_tick) begin
            if (state == SHIFT && bit_cnt > CNT_W'(1)) begin
                shreg_nxt = {IDLE_LVL, shreg[FRAME_W-1:1]};
                cnt_nxt   = bit_cnt - CNT_W'(1);
            end else begin
                done_nxt = (state == SHIFT);
                if (hold_valid || accept) begin
                    drain     = hold_valid;
                    bypass    = accept;
                    shreg_nxt = frame_new;
                    cnt_nxt   = CNT_W'(FRAME_W);
                    state_nxt = SHIFT;
                end else begin
                    shreg_nxt = {FRAME_W{IDLE_LVL}};
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= {FRAME_W{IDLE_LVL}};
            bit_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= cnt_nxt;
            done    <= done_nxt;
        end
    end

    assign txd  = shreg[0];
    assign busy = (state == SHIFT) || hold_valid;

endmodule

// File: tb/tb_irda_tx_framer.sv
// Self-checking bench: three framer configurations (8N1, 8E2, 8O2) against a bit-list frame model.
module tb_irda_tx_framer;

    typedef bit   bitq_t[$];
    typedef logic logq_t[$];

    logic       clk = 1'b0;
    logic       reset, bit_tick, load;
    logic [7:0] dat;
    logic ready_a, busy_a, txd_a, done_a, overrun_a;
    logic ready_b, busy_b, txd_b, done_b, overrun_b;
    logic ready_c, busy_c, txd_c, done_c, overrun_c;

    int    n_compared   = 0;
    int    n_mismatched = 0;
    int    cyc          = 0;
    int    phase        = 0;
    bit    tick_en      = 1'b1;
    int    done_cnt_a   = 0;
    int    ovr_cnt_a    = 0;
    logq_t seen_a, seen_b, seen_c;

    always #5 clk = ~clk;

    irda_tx_framer dut_a (
        .clk(clk), .reset(reset), .bit_tick(bit_tick), .load(load), .dat(dat),
        .ready(ready_a), .busy(busy_a), .txd(txd_a), .done(done_a), .overrun(overrun_a));

    irda_tx_framer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .bit_tick(bit_tick), .load(load), .dat(dat),
        .ready(ready_b), .busy(busy_b), .txd(txd_b), .done(done_b), .overrun(overrun_b));

    irda_tx_framer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_c (
        .clk(clk), .reset(reset), .bit_tick(bit_tick), .load(load), .dat(dat),
        .ready(ready_c), .busy(busy_c), .txd(txd_c), .done(done_c), .overrun(overrun_c));

    // Reference frame: start 0, data LSB-first, optional parity, stop 1s.
    function automatic bitq_t frame_bits(input int d, input int dw, input int pen,
                                         input int podd, input int sb);
        bitq_t q;
        int    ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            q.push_back(bit'((d >> i) & 1));
            ones += (d >> i) & 1;
        end
        if (pen != 0) q.push_back(bit'((ones % 2) ^ podd));
        for (int i = 0; i < sb; i++) q.push_back(1'b1);
        return q;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_stream(input string tag, input logq_t got, input bitq_t exp);
        check({tag, " length"}, 32'(got.size() >= exp.size()), 32'd1);
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("%s bit%0d", tag, i), 32'(got[i]),
                  (i < exp.size()) ? 32'(exp[i]) : 32'd1);
        end
    endtask

    // One clock: records txd of every instance after each tick edge, then drives next-cycle inputs.
    task automatic step();
        logic t;
        t = bit_tick;
        @(posedge clk);
        #1;
        cyc++;
        if (t) begin
            seen_a.push_back(txd_a);
            seen_b.push_back(txd_b);
            seen_c.push_back(txd_c);
        end
        if (done_a)    done_cnt_a++;
        if (overrun_a) ovr_cnt_a++;
        if (tick_en) begin
            phase    = (phase + 1) % 4;
            bit_tick = (phase == 0);
        end else begin
            bit_tick = 1'b0;
        end
        load = 1'b0;
    endtask

    task automatic clear_mon();
        seen_a.delete();
        seen_b.delete();
        seen_c.delete();
        done_cnt_a = 0;
        ovr_cnt_a  = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        step();
        step();
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic wait_seen(input int n, input int limit);
        int k = 0;
        while (seen_a.size() < n && k < limit) begin step(); k++; end
        check("wait_ticks", 32'(seen_a.size() >= n), 32'd1);
    endtask

    task automatic wait_ready(input int limit);
        int k = 0;
        while (ready_a !== 1'b1 && k < limit) begin step(); k++; end
        check("wait_ready", 32'(ready_a), 32'd1);
    endtask

    task automatic wait_done(input int n, input int limit);
        int k = 0;
        while (done_cnt_a < n && k < limit) begin step(); k++; end
        check("wait_done", 32'(done_cnt_a), 32'(n));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int    start_cyc, bad, n_frames;
        int    d;
        int    words[$];
        bitq_t exp;

        reset = 1'b1; load = 1'b0; dat = '0; bit_tick = 1'b0;
        #3;
        check("rst txd",     32'(txd_a),     32'd1);
        check("rst ready",   32'(ready_a),   32'd1);
        check("rst busy",    32'(busy_a),    32'd0);
        check("rst done",    32'(done_a),    32'd0);
        check("rst overrun", 32'(overrun_a), 32'd0);
        do_reset();

        $display("[TB] 8N1 single frame 0xA5");
        while (bit_tick) step();
        clear_mon();
        load = 1'b1; dat = 8'hA5; step();
        check("idle load txd",   32'(txd_a),   32'd1);
        check("idle load ready", 32'(ready_a), 32'd0);
        check("idle load busy",  32'(busy_a),  32'd1);
        wait_seen(1, 8);
        start_cyc = cyc;
        check("start bit", 32'(txd_a), 32'd0);
        wait_done(1, 60);
        check("done delay", 32'(cyc - start_cyc), 32'd40);
        compare_stream("a5 8N1", seen_a, frame_bits(8'hA5, 8, 0, 0, 1));
        step();
        check("busy after done", 32'(busy_a), 32'd0);
        check("done one clk",    32'(done_a), 32'd0);

        $display("[TB] parity configurations");
        for (int r = 0; r < 4; r++) begin
            d = (r == 0) ? 8'hA5 : int'($urandom_range(0, 255));
            do_reset();
            load = 1'b1; dat = 8'(d); step();
            repeat (14 * 4) step();
            compare_stream($sformatf("8N1 %02h", d), seen_a, frame_bits(d, 8, 0, 0, 1));
            compare_stream($sformatf("8E2 %02h", d), seen_b, frame_bits(d, 8, 1, 0, 2));
            compare_stream($sformatf("8O2 %02h", d), seen_c, frame_bits(d, 8, 1, 1, 2));
        end

        $display("[TB] back-to-back frames");
        do_reset();
        words = '{8'h55, 8'hF0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255))};
        n_frames = words.size();
        load = 1'b1; dat = 8'h55; step();
        wait_ready(20);
        repeat (6) step();
        load = 1'b1; dat = 8'hF0; step();
        check("ready after 2nd load", 32'(ready_a), 32'd0);
        for (int i = 2; i < n_frames; i++) begin
            wait_ready(80);
            load = 1'b1; dat = 8'(words[i]); step();
        end
        wait_done(n_frames, 200);
        exp.delete();
        foreach (words[i]) exp = {exp, frame_bits(words[i], 8, 0, 0, 1)};
        compare_stream("b2b", seen_a, exp);

        $display("[TB] overrun");
        do_reset();
        words = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255))};
        load = 1'b1; dat = 8'(words[0]); step();
        wait_ready(20);
        load = 1'b1; dat = 8'(words[1]); step();
        check("ovr ready", 32'(ready_a), 32'd0);
        load = 1'b1; dat = 8'h33; step();
        check("ovr pulse", 32'(overrun_a), 32'd1);
        step();
        check("ovr one clk", 32'(overrun_a), 32'd0);
        wait_done(2, 120);
        check("ovr count", 32'(ovr_cnt_a), 32'd1);
        exp = {frame_bits(words[0], 8, 0, 0, 1), frame_bits(words[1], 8, 0, 0, 1)};
        compare_stream("ovr stream", seen_a, exp);

        $display("[TB] reset mid-frame");
        do_reset();
        load = 1'b1; dat = 8'hA5; step();
        wait_seen(5, 40);
        check("bit4 before reset", 32'(txd_a), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("async rst txd",   32'(txd_a),   32'd1);
        check("async rst busy",  32'(busy_a),  32'd0);
        check("async rst ready", 32'(ready_a), 32'd1);
        step();
        reset = 1'b0;
        clear_mon();
        d = int'($urandom_range(0, 255));
        load = 1'b1; dat = 8'(d); step();
        repeat (12 * 4) step();
        compare_stream($sformatf("post rst %02h", d), seen_a, frame_bits(d, 8, 0, 0, 1));

        $display("[TB] no-tick hold");
        do_reset();
        tick_en = 1'b0; bit_tick = 1'b0;
        load = 1'b1; dat = 8'h81; step();
        bad = 0;
        repeat (50) begin
            step();
            if (txd_a !== 1'b1) bad++;
        end
        check("no tick txd idle", 32'(bad),     32'd0);
        check("no tick queued",   32'(ready_a), 32'd0);
        check("no tick seen",     32'(seen_a.size()), 32'd0);
        tick_en = 1'b1; phase = 0;
        wait_seen(1, 10);
        check("first tick start", 32'(txd_a), 32'd0);
        repeat (11 * 4) step();
        compare_stream("81 after hold", seen_a, frame_bits(8'h81, 8, 0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/irda_tx_framer.md
Name: irda_tx_framer

Overview:
- Parametrised successor to the fixed 12-bit TX shift register in the IrDA TXD path.
- Builds a complete UART/IrDA frame from parallel data and shifts it out LSB-first on a baud strobe: start bit, data, optional parity, 1–2 stop bits.
- Contains a one-entry holding buffer, so the controller can queue the next byte while the current one is shifting. Frames then go out back-to-back with no idle gap.
- Sits between the TX controller (which drives load/dat) and the baud counter (bit_tick) and the IR pulse encoder (txd).

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..16.
- PARITY_EN, 0, 1 = append a parity bit after the data.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1..2.
- Derived, not overridable: FRAME_W = 1 + DATA_W + PARITY_EN + STOP_BITS. With DATA_W=8, PARITY_EN=1, STOP_BITS=2, FRAME_W=12.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- bit_tick  in  1  one-clk baud strobe from the baud counter; one bit period elapses per tick.
- load  in  1  request to accept dat; honoured only when ready=1.
- dat  in  DATA_W  payload byte/word.
- ready  out  1  holding buffer empty; equals !hold_valid.
- busy  out  1  high when state==SHIFT or hold_valid.
- txd  out  1  serial output; equals shreg[0]; idle level 1.
- done  out  1  one-clk pulse when the last stop bit of a frame completes.
- overrun  out  1  one-clk pulse when load arrives while ready=0; that data is dropped.

Behaviour:
- Reset (async, takes effect immediately, including mid-frame):
  - shreg = all 1s, so txd=1.
  - state=IDLE, bit_cnt=0, hold_valid=0.
  - ready=1, busy=0, done=0, overrun=0.
  - Any partial frame is discarded.
- Frame layout in shreg, bit0 shifted first: [0]=start bit 0; [DATA_W:1]=dat; then the parity bit if enabled; then the stop bits, all 1.
  - Even parity bit = ^dat; odd parity bit = ~^dat.
- States: IDLE, SHIFT. bit_cnt is clog2(FRAME_W+1) wide and counts the bits remaining.
- Accepting data (posedge where load && ready):
  - If state==IDLE && bit_tick, bypass: build the frame from dat directly into shreg, bit_cnt=FRAME_W, go to SHIFT. hold_valid stays 0.
  - Otherwise capture dat into hold, hold_valid=1.
- IDLE && hold_valid && bit_tick: load the frame from hold, hold_valid=0, go to SHIFT. Frame start is always aligned to a tick, so every bit, including the start bit, lasts exactly one tick period.
- SHIFT on bit_tick with bit_cnt>1: shreg = {1'b1, shreg[FRAME_W-1:1]}, bit_cnt-1.
- SHIFT on bit_tick with bit_cnt==1 (end of the final stop bit):
  - done=1 for one clk.
  - If hold_valid: load the frame from hold, hold_valid=0, bit_cnt=FRAME_W, stay in SHIFT (back-to-back, zero gap).
  - Else if load && ready in the same cycle: load the frame from dat directly, stay in SHIFT.
  - Else: shreg=all 1s, go to IDLE.
- No bit_tick: shreg, bit_cnt and state hold their values. Only hold may change.
- Simultaneous capture and drain:
  - load && ready in the same cycle that hold drains into shreg is impossible, because ready=0 whenever hold_valid=1.
  - load on the cycle after a drain is accepted into hold.
- load while ready=0: hold is unchanged and overrun pulses for one clk.
- Latency:
  - Load at edge n in IDLE with no tick: txd falls at the first tick edge after n.
  - Load coincident with a tick in IDLE: txd=0 after that same edge.
  - done asserts on the edge that ends the bit at frame position FRAME_W-1.
- txd is registered: it is driven directly from shreg[0] with no combinational path from inputs.

Decomposition:
- Package irda_tx_pkg:
  - state enum {IDLE, SHIFT}.
  - function frame_w(DATA_W, PARITY_EN, STOP_BITS).
  - function build_frame(dat, PARITY_EN, PARITY_ODD, STOP_BITS), returning the FRAME_W vector.
  - constant IDLE_LVL = 1'b1.
- One natural sub-module: irda_tx_hold, the one-entry holding register with ready/overrun logic. The framer owns shreg, bit_cnt and the FSM.

Test Plan:
- Default params (8N1), bit_tick every 4 clk, load dat=8'hA5 in IDLE.
  - txd per tick: 0,1,0,1,0,0,1,0,1,1.
  - done pulses once, 40 clk after the first tick edge.
  - busy falls after done.
- DATA_W=8, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, dat=8'hA5.
  - 12-bit frame: 0,1,0,1,0,0,1,0,1, parity 0, stop 1,1.
  - Rerun with PARITY_ODD=1: parity bit becomes 1.
- Back-to-back: load 8'h55 in IDLE, then load 8'hF0 mid-frame.
  - ready goes 0 after the second load.
  - The start bit of 8'hF0 follows the stop bit of 8'h55 with no idle tick.
  - done pulses twice.
- Overrun: with hold_valid=1, assert load with 8'h33.
  - overrun pulses for 1 clk.
  - 8'h33 never appears on txd.
  - Queued data is intact.
- Reset mid-frame: assert reset at bit 4 of 8'hA5.
  - txd=1 immediately, without waiting for clk.
  - busy=0, ready=1.
  - After release, a new load transmits correctly.
- No-tick hold: load 8'h81, then withhold bit_tick for 50 clk.
  - txd stays 1, hold_valid=1.
  - The frame starts on the first tick after that.
